// File: rtl/pipe_stage_fifo_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo_pkg
//   Shared definitions for the inter-stage elastic buffer:
//   - ENABLE / DISABLE and payload field widths used to size stage payloads.
//   - EX_MEM_PAYLOAD_W: packed EX->MEM payload width (opt, rd, w_enable,
//     wdata, mem addr). Instantiations take DATA_W from here.
//   - xfer_e / xfer_kind(): classify one cycle's handshake activity.
// ---------------------------------------------------------------------------
package pipe_stage_fifo_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Stage payload field widths
    localparam int OPT_BUS_W      = 8;
    localparam int REG_ADDR_BUS_W = 5;
    localparam int W_ENABLE_W     = 1;
    localparam int REG_BUS_W      = 32;
    localparam int MEM_ADDR_W     = 18;

    // Packed EX->MEM payload: {opt, rd, w_enable, wdata, addr}
    localparam int EX_MEM_PAYLOAD_W = OPT_BUS_W + REG_ADDR_BUS_W + W_ENABLE_W
                                    + REG_BUS_W + MEM_ADDR_W;

    // Handshake activity in a cycle
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_PUSH = 2'b01,
        XFER_POP  = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    function automatic xfer_e xfer_kind(input logic push, input logic pop);
        return xfer_e'({pop, push});
    endfunction

endpackage

// File: rtl/pipe_stage_fifo_mem.sv
// ---------------------------------------------------------------------------
// pipe_stage_mem
//   DEPTH x DATA_W register array for the inter-stage buffer.
//   One synchronous write port, one asynchronous read port, async active-low
//   clear of every entry.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low clear
//   wr_en    in   write strobe
//   wr_addr  in   write entry index
//   wr_data  in   write payload
//   rd_addr  in   read entry index
//   rd_data  out  payload at rd_addr (combinational)
// ---------------------------------------------------------------------------
module pipe_stage_mem #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // One register per entry so the clear reaches every word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
//   Elastic inter-stage pipeline buffer (e.g. EX->MEM, IF->ID). Carries an
//   opaque DATA_W-bit payload through DEPTH entries with valid/ready
//   handshakes. rdy=0 freezes all state; flush discards buffered entries;
//   stall_req asks the stall controller to hold upstream when nearly full.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   rdy        in   global ready, 0 freezes state
//   flush      in   synchronous discard of all entries
//   up_valid   in   upstream payload valid
//   up_ready   out  buffer can accept
//   up_data    in   upstream payload
//   dn_valid   out  head entry valid
//   dn_ready   in   downstream accepts
//   dn_data    out  head payload, zero (bubble) when empty
//   count      out  occupancy
//   stall_req  out  count >= AFULL
// ---------------------------------------------------------------------------
module pipe_stage_fifo
    import pipe_stage_fifo_pkg::*;
#(
    parameter int DATA_W = EX_MEM_PAYLOAD_W,
    parameter int DEPTH  = 2,
    parameter int AFULL  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [DATA_W-1:0]          up_data,
    output logic                       dn_valid,
    input  logic                       dn_ready,
    output logic [DATA_W-1:0]          dn_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg,  count_next;
    logic [DATA_W-1:0] head_data;
    logic              active;
    logic              push;
    logic              pop;
    xfer_e             xfer;

    // Handshakes depend only on registered occupancy and the global
    // controls, never on the opposite side's valid/ready, so chained stages
    // cannot form a combinational loop. Holding up_ready low while rst is
    // asserted keeps upstream from seeing a phantom accept during reset.
    assign active   = rst & rdy & ~flush;
    assign up_ready = active & (count_reg != FULL_CNT);
    assign dn_valid = active & (count_reg != '0);

    assign push = up_valid & up_ready;
    assign pop  = dn_valid & dn_ready;
    assign xfer = xfer_kind(push, pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (rdy == ENABLE) begin
            if (flush == ENABLE) begin
                wr_ptr_next = '0;
                rd_ptr_next = '0;
                count_next  = '0;
            end else begin
                if (push) begin
                    wr_ptr_next = ptr_inc(wr_ptr_reg);
                end
                if (pop) begin
                    rd_ptr_next = ptr_inc(rd_ptr_reg);
                end
                case (xfer)
                    XFER_PUSH: count_next = count_reg + CNT_W'(1);
                    XFER_POP:  count_next = count_reg - CNT_W'(1);
                    default:   count_next = count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    pipe_stage_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (up_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_data)
    );

    // Empty buffer presents a zero payload: a NOP bubble with w_enable clear.
    assign dn_data   = (count_reg != '0) ? head_data : '0;
    assign count     = count_reg;
    assign stall_req = (count_reg >= AFULL_CNT);

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_fifo
//   Drives directed and random traffic into pipe_stage_fifo and compares the
//   outputs every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pipe_stage_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;
    logic [CNT_W-1:0]  count;
    logic              stall_req;

    int checks = 0;
    int errors = 0;

    // Reference model: in-order contents of the buffer.
    logic [DATA_W-1:0] model_q[$];

    pipe_stage_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AFULL  (AFULL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_data   (dn_data),
        .count     (count),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: sample at the falling edge, compare against the model, then
    // advance the model for the rising edge that follows (inputs are stable
    // from just after the rising edge until the next one).
    always @(negedge clk) begin
        int sz;
        logic act_ok, e_up, e_dv;
        logic [DATA_W-1:0] e_dd;
        if (!rst) begin
            model_q.delete();
            chk("rst_up_ready", longint'(up_ready), 0);
            chk("rst_dn_valid", longint'(dn_valid), 0);
            chk("rst_dn_data", longint'(dn_data), 0);
            chk("rst_count", longint'(count), 0);
            chk("rst_stall_req", longint'(stall_req), 0);
        end else begin
            sz     = model_q.size();
            act_ok = rdy && !flush;
            e_up   = act_ok && (sz < DEPTH);
            e_dv   = act_ok && (sz > 0);
            e_dd   = (sz > 0) ? model_q[0] : '0;
            chk("up_ready", longint'(up_ready), longint'(e_up));
            chk("dn_valid", longint'(dn_valid), longint'(e_dv));
            chk("dn_data", longint'(dn_data), longint'(e_dd));
            chk("count", longint'(count), longint'(sz));
            chk("stall_req", longint'(stall_req), longint'(sz >= AFULL));
            chk("count_bound", longint'(int'(count) <= DEPTH), 1);
            if (act_ok) begin
                if (e_dv && dn_ready) begin
                    $display("t=%0t POP  %h count=%0d", $time, model_q[0], sz);
                    void'(model_q.pop_front());
                end
                if (e_up && up_valid) begin
                    $display("t=%0t PUSH %h count=%0d", $time, up_data, sz);
                    model_q.push_back(up_data);
                end
            end else if (rdy && flush) begin
                $display("t=%0t FLUSH discards %0d entries", $time, sz);
                model_q.delete();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input logic [DATA_W-1:0] d);
        up_valid = 1'b1;
        up_data  = d;
        cyc();
    endtask

    initial begin
        rst      = 1'b0;
        rdy      = 1'b1;
        flush    = 1'b0;
        up_valid = 1'b1;
        up_data  = 16'h0099;
        dn_ready = 1'b0;
        repeat (3) cyc();
        rst      = 1'b1;
        up_valid = 1'b0;
        cyc();

        // Streaming, one transfer per cycle
        dn_ready = 1'b1;
        push_val(16'h0011);
        push_val(16'h0022);
        push_val(16'h0033);
        up_valid = 1'b0;
        repeat (2) cyc();

        // Backpressure up to full, extra push held, single pop
        dn_ready = 1'b0;
        push_val(16'h000A);
        push_val(16'h000B);
        push_val(16'h000C);
        push_val(16'h000D);
        push_val(16'h000E);
        push_val(16'h000E);
        up_valid = 1'b0;
        dn_ready = 1'b1;
        cyc();
        dn_ready = 1'b0;
        cyc();
        dn_ready = 1'b1;
        repeat (5) cyc();

        // Wrap with paired push/pop
        for (int i = 0; i < 10; i++) begin
            push_val(DATA_W'(i * 16'h0101));
        end
        up_valid = 1'b0;
        repeat (2) cyc();

        // Freeze with one entry held
        dn_ready = 1'b0;
        push_val(16'h0055);
        rdy      = 1'b0;
        dn_ready = 1'b1;
        up_valid = 1'b1;
        up_data  = 16'h0066;
        repeat (3) cyc();
        rdy      = 1'b1;
        up_valid = 1'b0;
        repeat (2) cyc();

        // Flush with a concurrent push that must be dropped
        dn_ready = 1'b0;
        push_val(16'h0001);
        push_val(16'h0002);
        flush    = 1'b1;
        up_valid = 1'b1;
        up_data  = 16'h0077;
        cyc();
        flush    = 1'b0;
        up_valid = 1'b0;
        cyc();

        // Flush during freeze is ignored
        push_val(16'h0003);
        push_val(16'h0004);
        up_valid = 1'b0;
        rdy      = 1'b0;
        flush    = 1'b1;
        cyc();
        rdy      = 1'b1;
        flush    = 1'b0;
        dn_ready = 1'b1;
        repeat (3) cyc();

        // Randomised traffic, including mid-transfer resets
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(0, 149) != 0);
            rdy      = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            up_valid = ($urandom_range(0, 3) != 0);
            dn_ready = ($urandom_range(0, 2) != 0);
            up_data  = DATA_W'($urandom);
            cyc();
        end
        rst = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
